gate_driver: RTL

GATE_DRIVER -- requirements
Module: gate_driver

---
 rtl/gate_driver.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/gate_driver.sv
// -----------------------------------------------------------------------------
// gate_driver
//
// Parking-barrier motor controller. It sequences the barrier through homing,
// raising, holding open and lowering. Every motor start or reversal is preceded
// by a dead-time window with both drives off. Travel is time-limited, and the
// barrier reverses to open whenever a car is detected or an open is requested
// while it is lowering.
//
// Parameters
//   DEAD_TIME   cycles with both motor drives low before any start/reversal
//   TRAVEL_MAX  maximum motor-on cycles for one travel before declaring fault
//   HOLD_TIME   cycles the gate stays open after the last open_req/car_present
//
// Ports
//   clk          in   system clock, all logic on the rising edge
//   reset        in   synchronous, active-low reset
//   open_req     in   open command pulse from the parking controller
//   close_req    in   early-close command pulse
//   car_present  in   debounced vehicle-under-barrier sensor (1 blocks closing)
//   lim_open     in   debounced fully-open limit switch
//   lim_closed   in   debounced fully-closed limit switch
//   motor_up     out  raise-barrier drive
//   motor_down   out  lower-barrier drive
//   gate_open    out  high while the gate is held open
//   gate_closed  out  high while the gate is closed and idle
//   fault        out  high once the controller has latched a fault
// -----------------------------------------------------------------------------
module gate_driver #(
  parameter int DEAD_TIME  = 4,
  parameter int TRAVEL_MAX = 1000,
  parameter int HOLD_TIME  = 5000
) (
  input  logic clk,
  input  logic reset,
  input  logic open_req,
  input  logic close_req,
  input  logic car_present,
  input  logic lim_open,
  input  logic lim_closed,
  output logic motor_up,
  output logic motor_down,
  output logic gate_open,
  output logic gate_closed,
  output logic fault
);

  // Each counter must be able to hold its full parameter value.
  localparam int DEAD_W   = (DEAD_TIME  < 1) ? 1 : $clog2(DEAD_TIME + 1);
  localparam int TRAVEL_W = (TRAVEL_MAX < 1) ? 1 : $clog2(TRAVEL_MAX + 1);
  localparam int HOLD_W   = (HOLD_TIME  < 1) ? 1 : $clog2(HOLD_TIME + 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_CLOSED,
    S_DEAD_UP,
    S_OPENING,
    S_OPEN_HOLD,
    S_DEAD_DOWN,
    S_CLOSING,
    S_FAULT
  } state_t;

  state_t state;
  state_t next_state;

  logic [DEAD_W-1:0]   dead_cnt;
  logic [TRAVEL_W-1:0] travel_cnt;
  logic [HOLD_W-1:0]   hold_cnt;

  // Counters hold the number of cycles remaining in the window, counting the
  // current cycle. A value of 1 therefore means "this is the last cycle": the
  // count reaches 0 on this edge and the transition is taken now. This gives
  // exactly DEAD_TIME dead cycles, TRAVEL_MAX motor cycles and HOLD_TIME quiet
  // open cycles.
  logic dead_done;
  logic travel_done;
  logic hold_done;

  logic both_limits;
  logic hold_activity;

  logic entering_dead;
  logic entering_travel;
  logic reload_hold;
  logic in_dead;
  logic in_travel;

  assign dead_done   = (dead_cnt   <= DEAD_W'(1));
  assign travel_done = (travel_cnt <= TRAVEL_W'(1));
  assign hold_done   = (hold_cnt   <= HOLD_W'(1));

  // Both limit switches active at once is physically impossible, so it points
  // to a wiring or sensor failure.
  assign both_limits   = lim_open & lim_closed;
  assign hold_activity = open_req | car_present;

  assign in_dead   = (state == S_DEAD_UP) || (state == S_DEAD_DOWN);
  assign in_travel = (state == S_OPENING) || (state == S_CLOSING);

  assign entering_dead   = ((next_state == S_DEAD_UP) || (next_state == S_DEAD_DOWN))
                           && (next_state != state);
  assign entering_travel = ((next_state == S_OPENING) || (next_state == S_CLOSING))
                           && (next_state != state);
  // The hold window restarts on entry and on every cycle with activity.
  assign reload_hold     = (next_state == S_OPEN_HOLD)
                           && ((state != S_OPEN_HOLD) || hold_activity);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: next_state gets a default before any branch, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    if (both_limits && (state != S_INIT) && (state != S_FAULT)) begin
      next_state = S_FAULT;
    end else begin
      case (state)
        S_INIT: begin
          // Home toward closed unless already there.
          next_state = lim_closed ? S_CLOSED : S_DEAD_DOWN;
        end
        S_CLOSED: begin
          if (open_req) next_state = S_DEAD_UP;
        end
        S_DEAD_UP: begin
          if (dead_done) next_state = S_OPENING;
        end
        S_OPENING: begin
          if (lim_open)         next_state = S_OPEN_HOLD;
          else if (travel_done) next_state = S_FAULT;
        end
        S_OPEN_HOLD: begin
          // open_req or a car keeps the gate open even against close_req.
          if (!hold_activity && (hold_done || close_req)) next_state = S_DEAD_DOWN;
        end
        S_DEAD_DOWN: begin
          if (dead_done) next_state = S_CLOSING;
        end
        S_CLOSING: begin
          // Safety reversal has priority over reaching the closed limit.
          if (open_req || car_present) next_state = S_DEAD_UP;
          else if (lim_closed)         next_state = S_CLOSED;
          else if (travel_done)        next_state = S_FAULT;
        end
        S_FAULT: begin
          next_state = S_FAULT;
        end
        default: begin
          next_state = S_FAULT;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State, counters and registered outputs
  // ---------------------------------------------------------------------------
  // Outputs are decoded from next_state and registered, so each output changes
  // on the same edge as the state it reflects, without combinational glitches.
  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: the counters are plain registers, not memories, so they are
      // cleared here together with the state; nothing relies on their
      // power-up value.
      state       <= S_INIT;
      dead_cnt    <= '0;
      travel_cnt  <= '0;
      hold_cnt    <= '0;
      motor_up    <= 1'b0;
      motor_down  <= 1'b0;
      gate_open   <= 1'b0;
      gate_closed <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state <= next_state;

      if (entering_dead) begin
        dead_cnt <= DEAD_W'(DEAD_TIME);
      end else if (in_dead) begin
        dead_cnt <= (dead_cnt == '0) ? '0 : dead_cnt - 1'b1;
      end

      if (entering_travel) begin
        travel_cnt <= TRAVEL_W'(TRAVEL_MAX);
      end else if (in_travel) begin
        travel_cnt <= (travel_cnt == '0) ? '0 : travel_cnt - 1'b1;
      end

      if (reload_hold) begin
        hold_cnt <= HOLD_W'(HOLD_TIME);
      end else if (state == S_OPEN_HOLD) begin
        hold_cnt <= (hold_cnt == '0) ? '0 : hold_cnt - 1'b1;
      end

      // Only one of OPENING/CLOSING can be the next state, so the drives are
      // mutually exclusive by construction.
      motor_up    <= (next_state == S_OPENING);
      motor_down  <= (next_state == S_CLOSING);
      gate_open   <= (next_state == S_OPEN_HOLD);
      gate_closed <= (next_state == S_CLOSED);
      fault       <= (next_state == S_FAULT);
    end
  end

endmodule
